// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and runs one-outstanding fetches to imem, buffering each word for decode.
// Latency: one instruction every 3 cycles with 1-cycle memory; decode backpressure holds the buffer and stalls fetch.
module fetch_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             misalign_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_instr_pc;
    logic             r_misalign;

    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_pc_next_seq;

    assign w_tgt         = {redirect_target[WIDTH-1:2], 2'b00};
    assign w_pc_next_seq = r_pc + WIDTH'(4);

    assign imem_req     = (r_state == REQ);
    assign imem_addr    = r_pc;
    assign instr_valid  = (r_state == HOLD);
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC[WIDTH-1:0];
            r_target   <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_target[1:0] != 2'b00);
            case (r_state)
                IDLE: begin
                    if (redirect_valid) r_pc <= w_tgt;
                    r_state <= REQ;
                end
                REQ: begin
                    // A grant coinciding with a redirect commits a stale fetch that must be drained.
                    if (imem_gnt) begin
                        if (redirect_valid) begin
                            r_target <= w_tgt;
                            r_state  <= DRAIN;
                        end else begin
                            r_state  <= WAIT;
                        end
                    end else if (redirect_valid) begin
                        r_pc <= w_tgt;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (imem_rvalid) begin
                            r_pc    <= w_tgt;
                            r_state <= REQ;
                        end else begin
                            r_target <= w_tgt;
                            r_state  <= DRAIN;
                        end
                    end else if (imem_rvalid) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_tgt;
                        r_state <= REQ;
                    end else if (instr_ready) begin
                        r_pc    <= w_pc_next_seq;
                        r_state <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) r_target <= w_tgt;
                    if (imem_rvalid) begin
                        r_pc    <= redirect_valid ? w_tgt : r_target;
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting in REQ at address pc: grant, answer one cycle later, then present to decode.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, pc}) begin
            errors++;
            $display("FAIL fetch_req: got req=%0b addr=%h, want req=1 addr=%h", imem_req, imem_addr, pc);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b0, 1'b0, pc}) begin
            errors++;
            $display("FAIL fetch_wait: got req=%0b vld=%0b addr=%h, want 0 0 %h", imem_req, instr_valid, imem_addr, pc);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if ({instr_valid, imem_req, instr, instr_pc} !== {1'b1, 1'b0, data, pc}) begin
            errors++;
            $display("FAIL fetch_hold: got vld=%0b req=%0b instr=%h pc=%h, want 1 0 %h %h", instr_valid, imem_req, instr, instr_pc, data, pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({imem_req, instr_valid, misalign_err, imem_addr, instr, instr_pc} !== {3'b000, 96'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b vld=%0b mis=%0b addr=%h instr=%h pc=%h, want all 0",
                     imem_req, instr_valid, misalign_err, imem_addr, instr, instr_pc);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_first_req: got req=%0b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        fetch_one(32'h0, 32'h1111_0000);
        fetch_one(32'h4, 32'h2222_0004);
        fetch_one(32'h8, 32'h3333_0008);
    endtask

    task automatic test_backpressure();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({instr_valid, imem_req, instr, instr_pc} !== {2'b10, 32'hCAFE_F00D, 32'hC}) begin
                errors++;
                $display("FAIL hold_stall[%0d]: got vld=%0b req=%0b instr=%h pc=%h, want 1 0 cafef00d 0000000c",
                         i, instr_valid, imem_req, instr, instr_pc);
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL hold_release: got req=%0b addr=%h, want 1 00000010", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_req, instr_valid} !== 2'b00) begin
                errors++;
                $display("FAIL drain_idle[%0d]: got req=%0b vld=%0b, want 0 0", i, imem_req, instr_valid);
            end
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h100}) begin
            errors++;
            $display("FAIL drain_discard: got vld=%0b req=%0b addr=%h, want 0 1 00000100", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        imem_gnt = 1'b1;
        tick();
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b1;
        imem_rdata      = 32'h0BAD_0100;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h200}) begin
            errors++;
            $display("FAIL wait_redirect_rvalid: got vld=%0b req=%0b addr=%h, want 0 1 00000200", instr_valid, imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0200;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL hold_0x200: got vld=%0b pc=%h, want 1 00000200", instr_valid, instr_pc);
        end
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h300}) begin
            errors++;
            $display("FAIL hold_redirect: got vld=%0b req=%0b addr=%h, want 0 1 00000300", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0106;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({misalign_err, imem_req, imem_addr} !== {2'b11, 32'h104}) begin
            errors++;
            $display("FAIL misalign_pulse: got mis=%0b req=%0b addr=%h, want 1 1 00000104", misalign_err, imem_req, imem_addr);
        end
        tick();
        checks++;
        if ({misalign_err, imem_addr} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL misalign_clear: got mis=%0b addr=%h, want 0 00000104", misalign_err, imem_addr);
        end
        // Redirect in the very cycle the fetch is granted: response must be drained.
        imem_gnt        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h400;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req, instr_valid, misalign_err} !== 3'b000) begin
            errors++;
            $display("FAIL req_gnt_redirect: got req=%0b vld=%0b mis=%0b, want 0 0 0", imem_req, instr_valid, misalign_err);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0104;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h400}) begin
            errors++;
            $display("FAIL req_gnt_drain: got vld=%0b req=%0b addr=%h, want 0 1 00000400", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h7777_FFFC);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap: got req=%0b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, instr_valid, misalign_err, imem_addr, instr, instr_pc} !== {3'b000, 96'h0}) begin
            errors++;
            $display("FAIL async_reset: got req=%0b vld=%0b mis=%0b addr=%h instr=%h pc=%h, want all 0",
                     imem_req, instr_valid, misalign_err, imem_addr, instr, instr_pc);
        end
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAAD_BAAD;
        tick();
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL reset_stale_idle: got vld=%0b req=%0b addr=%h, want 0 1 00000000", instr_valid, imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL reset_stale_req: got vld=%0b req=%0b addr=%h, want 0 1 00000000", instr_valid, imem_req, imem_addr);
        end
        fetch_one(32'h0, 32'h1357_9BDF);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_misalign();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
